// File: rtl/branch_stack_pkg.sv
// branch_stack_pkg: shared types for the branch-mask allocator and checkpoint store
package branch_stack_pkg;
  localparam int BS_B_W = 4;
  localparam int BS_CKPT_W = 64;
  typedef logic [BS_B_W-1:0] BMASK;
  typedef struct packed {
    logic                 valid;
    logic [31:0]          npc;
    logic [BS_CKPT_W-1:0] ckpt;
    BMASK                 dep;
  } BRANCH_STACK_ENTRY;
  typedef enum logic {NORMAL, RECOVER} BS_STATE;
endpackage

// File: rtl/branch_stack_free_sel.sv
// bs_free_sel: lowest-set-bit priority selector, one-hot result plus found flag
module bs_free_sel #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_onehot,
  output logic         o_found
);
  assign o_onehot = i_req & (~i_req + W'(1));
  assign o_found  = |i_req;
endmodule

// File: rtl/branch_stack.sv
// branch_stack: branch mask allocator and recovery checkpoint store (optional counters: BRANCH_STACK_STATS_EN)
module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int B_W    = BS_B_W,
  parameter int CKPT_W = BS_CKPT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  input  logic [31:0]       alloc_npc,
  input  logic [CKPT_W-1:0] alloc_ckpt,
  output logic              alloc_gnt,
  output logic [B_W-1:0]    alloc_bmm,
  output logic [B_W-1:0]    live_mask,
  output logic              full,
  input  logic              resolve_valid,
  input  logic [B_W-1:0]    resolve_bmm,
  input  logic [31:0]       resolve_target_pc,
  input  logic              resolve_taken,
  input  logic              resolve_mispred,
  output logic              clear_valid,
  output logic [B_W-1:0]    clear_bmm,
  output logic              squash_valid,
  output logic [B_W-1:0]    squash_mask,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
`ifdef BRANCH_STACK_STATS_EN
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred,
`endif
  output logic [CKPT_W-1:0] restore_ckpt
);
  logic [B_W-1:0]    r_valid;
  logic [31:0]       r_npc  [B_W];
  logic [CKPT_W-1:0] r_ckpt [B_W];
  logic [B_W-1:0]    r_dep  [B_W];
  BS_STATE           r_state, w_state_nxt;
  logic              w_normal, w_onehot, w_hit, w_mis, w_cor, w_found;
  logic [B_W-1:0]    w_squash, w_free, w_clr, w_sel;
  logic [31:0]       w_npc;
  logic [CKPT_W-1:0] w_ckpt;
  assign live_mask = r_valid;
  assign full      = &r_valid;
  // a resolve only counts when it names exactly one live entry; anything else is stale
  assign w_onehot = (resolve_bmm != '0) && ((resolve_bmm & (resolve_bmm - B_W'(1))) == '0);
  assign w_hit    = resolve_valid & w_onehot & |(resolve_bmm & r_valid);
  assign w_mis    = w_hit & resolve_mispred;
  assign w_cor    = w_hit & ~resolve_mispred;
  assign w_clr    = w_cor ? resolve_bmm : '0;
  assign w_free   = w_mis ? w_squash : w_clr;
  bs_free_sel #(.W(B_W)) u_sel (
    .i_req   (~r_valid),
    .o_onehot(w_sel),
    .o_found (w_found)
  );
  // squash set (resolver plus its dependents) and the resolver's saved npc/checkpoint
  always_comb begin
    w_squash = resolve_bmm;
    w_npc    = '0;
    w_ckpt   = '0;
    for (int j = 0; j < B_W; j++) begin
      w_squash[j] = resolve_bmm[j] | (r_valid[j] & |(r_dep[j] & resolve_bmm));
      w_npc       = w_npc | (resolve_bmm[j] ? r_npc[j] : '0);
      w_ckpt      = w_ckpt | (resolve_bmm[j] ? r_ckpt[j] : '0);
    end
  end
  // recovery lasts exactly one cycle
  always_ff @(posedge clock) r_state <= reset ? NORMAL : w_state_nxt;
  // leave NORMAL only on an accepted mispredict
  always_comb w_state_nxt = (r_state == NORMAL && w_mis) ? RECOVER : NORMAL;
  // grant only in NORMAL, never alongside a mispredict; freed bits wait a cycle
  always_comb begin
    w_normal  = r_state == NORMAL;
    alloc_gnt = alloc_req & w_found & w_normal & ~w_mis;
    alloc_bmm = alloc_gnt ? w_sel : '0;
  end
  // entry table: free on resolve, clear dependency bits, capture new branch
  always_ff @(posedge clock) begin
    if (reset) r_valid <= '0;
    else begin
      r_valid <= (r_valid & ~w_free) | alloc_bmm;
      for (int j = 0; j < B_W; j++) begin
        r_dep[j] <= r_dep[j] & ~w_clr;
        if (alloc_bmm[j]) begin
          r_npc[j]  <= alloc_npc;
          r_ckpt[j] <= alloc_ckpt;
          r_dep[j]  <= r_valid & ~w_clr;
        end
      end
    end
  end
  // one-cycle broadcast of clear, squash and redirect, zero otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_valid    <= 1'b0;
      clear_bmm      <= '0;
      squash_valid   <= 1'b0;
      squash_mask    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      restore_ckpt   <= '0;
    end else begin
      clear_valid    <= w_hit;
      clear_bmm      <= w_hit ? resolve_bmm : '0;
      squash_valid   <= w_mis;
      squash_mask    <= w_mis ? w_squash : '0;
      redirect_valid <= w_mis;
      redirect_pc    <= w_mis ? (resolve_taken ? w_npc : resolve_target_pc) : '0;
      restore_ckpt   <= w_mis ? w_ckpt : '0;
    end
  end
`ifdef BRANCH_STACK_STATS_EN
  // saturating counts of accepted resolves and mispredicts
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (w_hit && !(&stat_resolved)) stat_resolved <= stat_resolved + 32'd1;
      if (w_mis && !(&stat_mispred)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_stack.sv
// tb_branch_stack: directed scoreboard bench for branch_stack (stats checked when BRANCH_STACK_STATS_EN is defined)
module tb_branch_stack;
  typedef struct packed {
    logic        cv;
    logic [3:0]  cb;
    logic        sv;
    logic [3:0]  sm;
    logic        rv;
    logic [31:0] pc;
    logic [63:0] ck;
  } out_t;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_req = 1'b0;
  logic [31:0] alloc_npc = '0;
  logic [63:0] alloc_ckpt = '0;
  logic        alloc_gnt, full, clear_valid, squash_valid, redirect_valid;
  logic [3:0]  alloc_bmm, live_mask, clear_bmm, squash_mask;
  logic        resolve_valid = 1'b0, resolve_taken = 1'b0, resolve_mispred = 1'b0;
  logic [3:0]  resolve_bmm = '0;
  logic [31:0] resolve_target_pc = '0;
  logic [31:0] redirect_pc;
  logic [63:0] restore_ckpt;
`ifdef BRANCH_STACK_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif
  int   n_assert = 0;
  int   n_fail = 0;
  out_t q[$];
  always #5 clock = ~clock;
  branch_stack dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_npc(alloc_npc), .alloc_ckpt(alloc_ckpt),
    .alloc_gnt(alloc_gnt), .alloc_bmm(alloc_bmm), .live_mask(live_mask), .full(full),
    .resolve_valid(resolve_valid), .resolve_bmm(resolve_bmm), .resolve_target_pc(resolve_target_pc),
    .resolve_taken(resolve_taken), .resolve_mispred(resolve_mispred),
    .clear_valid(clear_valid), .clear_bmm(clear_bmm),
    .squash_valid(squash_valid), .squash_mask(squash_mask),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef BRANCH_STACK_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred),
`endif
    .restore_ckpt(restore_ckpt)
  );
  function automatic logic [63:0] ck(input int i);
    return 64'hC0C0_0000_0000_0000 | 64'(i);
  endfunction
  function automatic out_t mk(input logic cv, input logic [3:0] cb, input logic sv, input logic [3:0] sm,
                              input logic rv, input logic [31:0] pc, input logic [63:0] c);
    return {cv, cb, sv, sm, rv, pc, c};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input out_t o, input logic [3:0] e_live);
    chk("clear_valid", {63'b0, clear_valid}, {63'b0, o.cv});
    chk("clear_bmm", {60'b0, clear_bmm}, {60'b0, o.cb});
    chk("squash_valid", {63'b0, squash_valid}, {63'b0, o.sv});
    chk("squash_mask", {60'b0, squash_mask}, {60'b0, o.sm});
    chk("redirect_valid", {63'b0, redirect_valid}, {63'b0, o.rv});
    chk("redirect_pc", {32'b0, redirect_pc}, {32'b0, o.pc});
    chk("restore_ckpt", restore_ckpt, o.ck);
    chk("live_mask", {60'b0, live_mask}, {60'b0, e_live});
    chk("full", {63'b0, full}, {63'b0, &e_live});
  endtask
  // one cycle: drive, check grant, push expected registered outputs, pop after the edge
  task automatic step(input logic a_req, input logic [31:0] a_npc, input logic [63:0] a_ck,
                      input logic r_v, input logic [3:0] r_b, input logic [31:0] r_tgt,
                      input logic r_tk, input logic r_mp,
                      input logic [3:0] e_bmm, input out_t e_out, input logic [3:0] e_live);
    alloc_req = a_req; alloc_npc = a_npc; alloc_ckpt = a_ck;
    resolve_valid = r_v; resolve_bmm = r_b; resolve_target_pc = r_tgt;
    resolve_taken = r_tk; resolve_mispred = r_mp;
    #1;
    chk("alloc_gnt", {63'b0, alloc_gnt}, {63'b0, |e_bmm});
    chk("alloc_bmm", {60'b0, alloc_bmm}, {60'b0, e_bmm});
    q.push_back(e_out);
    @(posedge clock);
    #1;
    chk_out(q.pop_front(), e_live);
    @(negedge clock);
  endtask
  task automatic al(input logic [31:0] npc, input logic [63:0] c, input logic [3:0] e_bmm, input logic [3:0] e_live);
    step(1'b1, npc, c, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, e_bmm, '0, e_live);
  endtask
  task automatic rs(input logic [3:0] b, input logic [31:0] tgt, input logic tk, input logic mp,
                    input out_t e_out, input logic [3:0] e_live);
    step(1'b0, 32'h0, 64'h0, 1'b1, b, tgt, tk, mp, 4'h0, e_out, e_live);
  endtask
  task automatic do_reset();
    reset = 1'b1; alloc_req = 1'b0; resolve_valid = 1'b0; resolve_mispred = 1'b0;
    @(posedge clock);
    #1;
    chk_out('0, 4'h0);
    reset = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    @(negedge clock);
    do_reset();
    do_reset();
    // fill all four slots, fifth request refused
    al(32'h10, ck(0), 4'b0001, 4'b0001);
    al(32'h14, ck(1), 4'b0010, 4'b0011);
    al(32'h18, ck(2), 4'b0100, 4'b0111);
    al(32'h1c, ck(3), 4'b1000, 4'b1111);
    al(32'h20, ck(4), 4'b0000, 4'b1111);
    do_reset();
    // correct resolve with same-cycle alloc, then mispredict not-taken with same-cycle alloc
    al(32'h10, ck(0), 4'b0001, 4'b0001);
    al(32'h20, ck(1), 4'b0010, 4'b0011);
    step(1'b1, 32'h30, ck(2), 1'b1, 4'b0001, 32'h0, 1'b0, 1'b0, 4'b0100,
         mk(1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 32'h0, 64'h0), 4'b0110);
    step(1'b1, 32'h40, ck(3), 1'b1, 4'b0010, 32'h4000, 1'b0, 1'b1, 4'b0000,
         mk(1'b1, 4'b0010, 1'b1, 4'b0110, 1'b1, 32'h4000, ck(1)), 4'b0000);
    step(1'b1, 32'h50, ck(4), 1'b1, 4'b0100, 32'h0, 1'b0, 1'b0, 4'b0000, '0, 4'b0000);
    al(32'h60, ck(5), 4'b0001, 4'b0001);
    do_reset();
    // mispredict taken on middle branch squashes its dependent
    al(32'h100, ck(0), 4'b0001, 4'b0001);
    al(32'h200, ck(1), 4'b0010, 4'b0011);
    al(32'h300, ck(2), 4'b0100, 4'b0111);
    rs(4'b0010, 32'h9999, 1'b1, 1'b1, mk(1'b1, 4'b0010, 1'b1, 4'b0110, 1'b1, 32'h200, ck(1)), 4'b0001);
    step(1'b1, 32'h400, ck(3), 1'b1, 4'b0001, 32'h0, 1'b0, 1'b0, 4'b0000,
         mk(1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 32'h0, 64'h0), 4'b0000);
    al(32'h500, ck(4), 4'b0001, 4'b0001);
    al(32'h600, ck(5), 4'b0010, 4'b0011);
    // malformed or invalid resolves are ignored
    rs(4'b0011, 32'h0, 1'b0, 1'b0, '0, 4'b0011);
    rs(4'b0000, 32'h0, 1'b0, 1'b1, '0, 4'b0011);
    step(1'b0, 32'h0, 64'h0, 1'b0, 4'b0001, 32'h0, 1'b0, 1'b1, 4'h0, '0, 4'b0011);
    rs(4'b0001, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b0001, 1'b0, 4'h0, 1'b0, 32'h0, 64'h0), 4'b0010);
    rs(4'b0010, 32'h0, 1'b0, 1'b0, mk(1'b1, 4'b0010, 1'b0, 4'h0, 1'b0, 32'h0, 64'h0), 4'b0000);
    al(32'h700, ck(6), 4'b0001, 4'b0001);
    rs(4'b0001, 32'h8000, 1'b0, 1'b1, mk(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h8000, ck(6)), 4'b0000);
`ifdef BRANCH_STACK_STATS_EN
    chk("stat_resolved", {32'b0, stat_resolved}, 64'd5);
    chk("stat_mispred", {32'b0, stat_mispred}, 64'd2);
`endif
    // reset while in RECOVER
    do_reset();
`ifdef BRANCH_STACK_STATS_EN
    chk("stat_resolved_rst", {32'b0, stat_resolved}, 64'd0);
    chk("stat_mispred_rst", {32'b0, stat_mispred}, 64'd0);
`endif
    al(32'h800, ck(7), 4'b0001, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_stack.md
# branch_stack

Branch-mask allocator and checkpoint store sitting between dispatch and the branch execution unit. Hands out a one-hot branch mask bit and stores a recovery checkpoint per in-flight branch at dispatch, then consumes the branch unit's resolution packet: correct predictions free and broadcast-clear the bit, mispredictions drive a one-cycle recovery (squash mask, redirect PC, checkpoint restore).

## Interface
- `B_W`, default 4: number of in-flight branches; the mask width.
- `CKPT_W`, default 64: width of the opaque checkpoint payload (map-table/free-list/ROB pointers).
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `alloc_req` in 1: dispatch wants a branch slot.
- `alloc_npc` in 32: fall-through PC of the branch.
- `alloc_ckpt` in CKPT_W: checkpoint to save.
- `alloc_gnt` out 1: combinational grant.
- `alloc_bmm` out B_W: one-hot bit granted; 0 when no grant.
- `live_mask` out B_W: registered mask of in-flight branches; dispatch tags new instructions with it.
- `full` out 1: `live_mask` is all ones.
- `resolve_valid` in 1: branch result valid.
- `resolve_bmm` in B_W: one-hot bit of the resolving branch.
- `resolve_target_pc` in 32: computed taken target.
- `resolve_taken` in 1: predicted direction.
- `resolve_mispred` in 1: prediction wrong.
- `clear_valid` out 1, `clear_bmm` out B_W: registered broadcast; consumers clear this bit.
- `squash_valid` out 1, `squash_mask` out B_W: registered; kill every instruction whose mask intersects.
- `redirect_valid` out 1, `redirect_pc` out 32, `restore_ckpt` out CKPT_W: registered recovery outputs.

## Operation
- Per entry i: `valid`, `npc`, `ckpt`, `dep` (B_W, the `live_mask` at allocation).
- Grant: `alloc_gnt = alloc_req & ~full & state==NORMAL & ~(resolve_valid & resolve_mispred & accepted)`; lowest free index wins.
- Resolve is accepted only if `resolve_bmm` is exactly one-hot and that entry is valid; otherwise ignored (stale, already squashed).
- Correct resolve of i: free i, clear bit i from every `dep`, `clear_valid`/`clear_bmm = 1<<i` next cycle.
- Mispredict of i: `squash_mask = (1<<i) | {j : valid[j] & dep[j][i]}`; free every entry in `squash_mask`; `redirect_pc = resolve_taken ? npc[i] : resolve_target_pc`; `restore_ckpt = ckpt[i]`; FSM to RECOVER. `clear_valid` also pulses with bit i.
- FSM: NORMAL → RECOVER on accepted mispredict; RECOVER → NORMAL unconditionally next cycle. In RECOVER, grant is 0; resolves are still accepted but only if the entry survived the squash.
- Same-cycle alloc plus correct resolve: the freed bit is not re-granted this cycle, and the new entry's `dep` excludes the clearing bit.
- Same-cycle alloc plus accepted mispredict: no grant.
- Reset: all entries invalid, FSM NORMAL, all outputs 0 (`live_mask` 0, `full` 0, `redirect_pc` 0, `restore_ckpt` 0).

## Timing
- Resolve sampled at edge ending cycle N → `clear_*`, `squash_*`, `redirect_*` valid during N+1 for exactly one cycle, then 0.
- `live_mask` reflects frees and allocs from cycle N in cycle N+1.
- Grant latency 0 (combinational); stored entry visible in `live_mask` next cycle.
- A resolve during RECOVER whose bit was in the prior `squash_mask` is ignored.
- Reset mid-RECOVER: next cycle is NORMAL with all outputs 0.

## Configuration
- `BRANCH_STACK_STATS_EN`: when defined, adds outputs `stat_resolved` and `stat_mispred` (32 bits each, saturating, reset to 0), counting accepted resolves and accepted mispredicts. When undefined, the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Shared package: `BMASK` typedef (B_W bits), `BRANCH_STACK_ENTRY` struct (valid/npc/ckpt/dep), `BS_STATE` enum {NORMAL, RECOVER}.
- One sub-module: `bs_free_sel`, a lowest-set-bit priority selector producing a one-hot output plus a found flag.

## Test plan
- Reset, then 4 back-to-back `alloc_req` → `alloc_bmm` 0001, 0010, 0100, 1000; `full`=1; 5th request gets `alloc_gnt`=0.
- Alloc bits 0 and 1, then correct resolve of bmm 0001 → next cycle `clear_bmm`=0001, `live_mask`=0010, entry 1 `dep`=0.
- Alloc 0,1,2 (npc 0x100/0x200/0x300), mispredict bmm 0010 with taken=1 → `squash_mask`=0110, `redirect_pc`=0x200, `restore_ckpt`=ckpt1, `live_mask`=0001.
- Mispredict with taken=0, target 0x4000 → `redirect_pc`=0x4000; same-cycle `alloc_req` gets `alloc_gnt`=0; no grant during RECOVER.
- Resolve of a squashed bit during RECOVER, and resolve with bmm 0011 → ignored, no output pulses.
- With `BRANCH_STACK_STATS_EN` defined: 3 correct resolves plus 2 mispredicts → `stat_resolved`=5, `stat_mispred`=2.
